// File: rtl/pc_interrupt_controller.sv
// Interrupt entry/return sequencer for the program counter.
// Latches INT0/INT1, arbitrates at COMMIT, steers PC_NEXTX on FETCH.
module pc_interrupt_controller #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       FETCH,
   input  logic       COMMIT,
   input  logic       INT0,
   input  logic       INT1,
   input  logic       EI,
   input  logic       DI,
   input  logic       RETI,
   output logic [2:0] PC_NEXTX,
   output logic       PC_LD_INT0X,
   output logic       PC_LD_INT1X,
   output logic       PC_FORCE_EN,
   output logic       INT_ACK0,
   output logic       INT_ACK1,
   output logic       IE,
   output logic       IN_SVC0,
   output logic       IN_SVC1
);

   localparam logic [2:0] PC_NEXTX_NEXT  = 3'd0;
   localparam logic [2:0] PC_NEXTX_INTV0 = 3'd3;
   localparam logic [2:0] PC_NEXTX_INTV1 = 3'd4;
   localparam logic [2:0] PC_NEXTX_INTR0 = 3'd5;
   localparam logic [2:0] PC_NEXTX_INTR1 = 3'd6;

   typedef enum logic [2:0] {
      RUN  = 3'd0,
      ENT0 = 3'd1,
      ENT1 = 3'd2,
      RET0 = 3'd3,
      RET1 = 3'd4
   } state_t;

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] sync0_q, sync1_q;
   logic [1:0]             dly0_q, dly1_q;
   logic                   pend0_q, pend1_q;
   logic                   edge0, edge1;
   logic                   ret0_done, ret1_done;

   logic [2:0] nextx_d;
   logic       ld0_d, ld1_d, force_d;

   // Two delay flops after the synchroniser: edge is registered into PEND
   assign edge0 = dly0_q[0] & ~dly0_q[1];
   assign edge1 = dly1_q[0] & ~dly1_q[1];

   assign INT_ACK0  = (state_q == ENT0) & FETCH;
   assign INT_ACK1  = (state_q == ENT1) & FETCH;
   assign ret0_done = (state_q == RET0) & FETCH;
   assign ret1_done = (state_q == RET1) & FETCH;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN: begin
            if (COMMIT) begin
               if (RETI && IN_SVC0)
                  state_d = RET0;
               else if (RETI && IN_SVC1)
                  state_d = RET1;
               else if (IE && pend0_q && !IN_SVC0)
                  state_d = ENT0;
               else if (IE && pend1_q && !IN_SVC0 && !IN_SVC1)
                  state_d = ENT1;
            end
         end
         ENT0, ENT1, RET0, RET1: begin
            if (FETCH)
               state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      nextx_d = PC_NEXTX_NEXT;
      ld0_d   = 1'b0;
      ld1_d   = 1'b0;
      force_d = 1'b0;
      unique case (state_d)
         ENT0: begin
            nextx_d = PC_NEXTX_INTV0;
            ld0_d   = 1'b1;
            force_d = 1'b1;
         end
         ENT1: begin
            nextx_d = PC_NEXTX_INTV1;
            ld1_d   = 1'b1;
            force_d = 1'b1;
         end
         RET0: begin
            nextx_d = PC_NEXTX_INTR0;
            force_d = 1'b1;
         end
         RET1: begin
            nextx_d = PC_NEXTX_INTR1;
            force_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= RUN;
         PC_NEXTX    <= PC_NEXTX_NEXT;
         PC_LD_INT0X <= 1'b0;
         PC_LD_INT1X <= 1'b0;
         PC_FORCE_EN <= 1'b0;
      end else begin
         state_q     <= state_d;
         PC_NEXTX    <= nextx_d;
         PC_LD_INT0X <= ld0_d;
         PC_LD_INT1X <= ld1_d;
         PC_FORCE_EN <= force_d;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         sync0_q <= '0;
         sync1_q <= '0;
         dly0_q  <= '0;
         dly1_q  <= '0;
      end else begin
         sync0_q <= {sync0_q[SYNC_STAGES-2:0], INT0};
         sync1_q <= {sync1_q[SYNC_STAGES-2:0], INT1};
         dly0_q  <= {dly0_q[0], sync0_q[SYNC_STAGES-1]};
         dly1_q  <= {dly1_q[0], sync1_q[SYNC_STAGES-1]};
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         pend0_q <= 1'b0;
         pend1_q <= 1'b0;
         IN_SVC0 <= 1'b0;
         IN_SVC1 <= 1'b0;
         IE      <= 1'b0;
      end else begin
         if (edge0)
            pend0_q <= 1'b1;
         else if (INT_ACK0)
            pend0_q <= 1'b0;
         if (edge1)
            pend1_q <= 1'b1;
         else if (INT_ACK1)
            pend1_q <= 1'b0;
         if (INT_ACK0)
            IN_SVC0 <= 1'b1;
         else if (ret0_done)
            IN_SVC0 <= 1'b0;
         if (INT_ACK1)
            IN_SVC1 <= 1'b1;
         else if (ret1_done)
            IN_SVC1 <= 1'b0;
         // IE change is seen by the following COMMIT decision
         if (COMMIT) begin
            if (DI)
               IE <= 1'b0;
            else if (EI)
               IE <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pc_interrupt_controller.sv
// Randomised bench for pc_interrupt_controller against an
// instruction-level model of pending, in-service and enable state.
module tb_pc_interrupt_controller;

   localparam int SYNC_STAGES = 2;

   localparam logic [2:0] NX_NEXT  = 3'd0;
   localparam logic [2:0] NX_INTV0 = 3'd3;
   localparam logic [2:0] NX_INTV1 = 3'd4;
   localparam logic [2:0] NX_INTR0 = 3'd5;
   localparam logic [2:0] NX_INTR1 = 3'd6;

   localparam int D_NONE = 0;
   localparam int D_ENT0 = 1;
   localparam int D_ENT1 = 2;
   localparam int D_RET0 = 3;
   localparam int D_RET1 = 4;

   logic       CLK = 1'b0;
   logic       RESET_N = 1'b0;
   logic       FETCH = 1'b0;
   logic       COMMIT = 1'b0;
   logic       INT0 = 1'b0;
   logic       INT1 = 1'b0;
   logic       EI = 1'b0;
   logic       DI = 1'b0;
   logic       RETI = 1'b0;
   logic [2:0] PC_NEXTX;
   logic       PC_LD_INT0X, PC_LD_INT1X, PC_FORCE_EN;
   logic       INT_ACK0, INT_ACK1, IE, IN_SVC0, IN_SVC1;

   int n_chk = 0;
   int n_fail = 0;

   bit m_pend0, m_pend1, m_svc0, m_svc1, m_ie;

   logic [2:0] nx_tab [5];

   pc_interrupt_controller #(
      .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .FETCH      (FETCH),
      .COMMIT     (COMMIT),
      .INT0       (INT0),
      .INT1       (INT1),
      .EI         (EI),
      .DI         (DI),
      .RETI       (RETI),
      .PC_NEXTX   (PC_NEXTX),
      .PC_LD_INT0X(PC_LD_INT0X),
      .PC_LD_INT1X(PC_LD_INT1X),
      .PC_FORCE_EN(PC_FORCE_EN),
      .INT_ACK0   (INT_ACK0),
      .INT_ACK1   (INT_ACK1),
      .IE         (IE),
      .IN_SVC0    (IN_SVC0),
      .IN_SVC1    (IN_SVC1)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic int decide(input bit reti);
      if (reti && m_svc0) return D_RET0;
      if (reti && m_svc1) return D_RET1;
      if (m_ie && m_pend0 && !m_svc0) return D_ENT0;
      if (m_ie && m_pend1 && !m_svc0 && !m_svc1) return D_ENT1;
      return D_NONE;
   endfunction

   task automatic model_reset();
      m_pend0 = 0;
      m_pend1 = 0;
      m_svc0  = 0;
      m_svc1  = 0;
      m_ie    = 0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_nextx"}, 32'(PC_NEXTX), 32'(NX_NEXT));
      chk({tag, "_ld0"}, 32'(PC_LD_INT0X), 0);
      chk({tag, "_ld1"}, 32'(PC_LD_INT1X), 0);
      chk({tag, "_force"}, 32'(PC_FORCE_EN), 0);
      chk({tag, "_ack"}, {30'd0, INT_ACK1, INT_ACK0}, 0);
   endtask

   task automatic do_instr(input bit p0, input bit p1, input bit ei,
                           input bit di, input bit reti);
      int dec;
      if (p0 || p1) begin
         INT0 = p0;
         INT1 = p1;
         tick();
         tick();
         INT0 = 1'b0;
         INT1 = 1'b0;
      end
      repeat (SYNC_STAGES + 4) tick();
      m_pend0 |= p0;
      m_pend1 |= p1;
      dec = decide(reti);
      COMMIT = 1'b1;
      EI     = ei;
      DI     = di;
      RETI   = reti;
      tick();
      COMMIT = 1'b0;
      EI     = 1'b0;
      DI     = 1'b0;
      RETI   = 1'b0;
      if (di) m_ie = 0;
      else if (ei) m_ie = 1;
      tick();
      @(negedge CLK);
      chk("sel_nextx", 32'(PC_NEXTX), 32'(nx_tab[dec]));
      chk("sel_ld0", 32'(PC_LD_INT0X), 32'(dec == D_ENT0));
      chk("sel_ld1", 32'(PC_LD_INT1X), 32'(dec == D_ENT1));
      chk("sel_force", 32'(PC_FORCE_EN), 32'(dec != D_NONE));
      @(posedge CLK);
      #1;
      FETCH = 1'b1;
      @(negedge CLK);
      chk("fetch_nextx", 32'(PC_NEXTX), 32'(nx_tab[dec]));
      chk("fetch_ack0", 32'(INT_ACK0), 32'(dec == D_ENT0));
      chk("fetch_ack1", 32'(INT_ACK1), 32'(dec == D_ENT1));
      @(posedge CLK);
      #1;
      FETCH = 1'b0;
      case (dec)
         D_ENT0: begin m_svc0 = 1; m_pend0 = 0; end
         D_ENT1: begin m_svc1 = 1; m_pend1 = 0; end
         D_RET0: m_svc0 = 0;
         D_RET1: m_svc1 = 0;
         default: ;
      endcase
      @(negedge CLK);
      chk("svc0", 32'(IN_SVC0), 32'(m_svc0));
      chk("svc1", 32'(IN_SVC1), 32'(m_svc1));
      chk("ie", 32'(IE), 32'(m_ie));
      chk_idle("post");
   endtask

   task automatic do_reset();
      RESET_N = 1'b0;
      #1;
      model_reset();
      chk_idle("rst");
      chk("rst_ie", 32'(IE), 0);
      chk("rst_svc", {30'd0, IN_SVC1, IN_SVC0}, 0);
      repeat (2) tick();
      RESET_N = 1'b1;
      tick();
   endtask

   initial begin
      nx_tab[D_NONE] = NX_NEXT;
      nx_tab[D_ENT0] = NX_INTV0;
      nx_tab[D_ENT1] = NX_INTV1;
      nx_tab[D_RET0] = NX_INTR0;
      nx_tab[D_RET1] = NX_INTR1;
      model_reset();
      #2;
      do_reset();

      // FETCH with no prior decision
      FETCH = 1'b1;
      @(negedge CLK);
      chk_idle("stray");
      tick();
      FETCH = 1'b0;
      @(negedge CLK);
      chk_idle("stray_after");

      do_instr(0, 1, 1, 0, 0);
      do_instr(0, 0, 0, 0, 0);
      do_instr(1, 0, 0, 0, 0);
      do_instr(0, 0, 0, 0, 1);
      do_instr(0, 0, 0, 0, 1);
      do_instr(1, 1, 0, 0, 0);
      do_instr(0, 0, 0, 0, 1);
      do_instr(0, 0, 0, 0, 0);
      do_instr(1, 0, 0, 0, 1);
      do_instr(0, 0, 0, 0, 0);
      do_instr(0, 0, 0, 0, 1);
      do_instr(0, 0, 0, 0, 1);
      do_instr(0, 0, 1, 1, 0);
      do_instr(1, 0, 0, 0, 0);
      do_instr(0, 0, 1, 0, 0);
      do_instr(0, 0, 0, 0, 0);
      do_instr(0, 0, 0, 0, 1);

      for (int i = 0; i < 200; i++) begin
         bit p0, p1, ei, di, reti;
         p0   = ($urandom % 5) == 0;
         p1   = ($urandom % 4) == 0;
         ei   = ($urandom % 3) == 0;
         di   = ($urandom % 8) == 0;
         reti = (m_svc0 || m_svc1) ? (($urandom % 2) == 0)
                                   : (($urandom % 10) == 0);
         do_instr(p0, p1, ei, di, reti);
      end

      // Reset while sitting in ENT0 abandons the entry
      do_reset();
      do_instr(0, 0, 1, 0, 0);
      INT0 = 1'b1;
      tick();
      tick();
      INT0 = 1'b0;
      repeat (SYNC_STAGES + 4) tick();
      COMMIT = 1'b1;
      tick();
      COMMIT = 1'b0;
      tick();
      @(negedge CLK);
      chk("mid_nextx", 32'(PC_NEXTX), 32'(NX_INTV0));
      chk("mid_ld0", 32'(PC_LD_INT0X), 1);
      RESET_N = 1'b0;
      #1;
      model_reset();
      chk_idle("mid_rst");
      chk("mid_rst_ie", 32'(IE), 0);
      @(posedge CLK);
      #1;
      RESET_N = 1'b1;
      FETCH = 1'b1;
      @(negedge CLK);
      chk_idle("mid_fetch");
      tick();
      FETCH = 1'b0;
      @(negedge CLK);
      chk("mid_svc0", 32'(IN_SVC0), 0);
      do_instr(0, 0, 1, 0, 0);
      do_instr(0, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_interrupt_controller.md
# pc_interrupt_controller

Sequencer for the program counter's interrupt-entry and interrupt-return paths. It latches the two external interrupt requests and arbitrates them by fixed priority at instruction boundaries. It then drives the PC next-address select and the INTR0/INTR1 save strobes, so that the program counter vectors to INTV0/INTV1 and later resumes from the saved address. It sits between the instruction decoder/phase generator and the program counter.

## Interface
Parameters:
- SYNC_STAGES, 2: synchroniser depth on INT0/INT1 pins (legal 2..3).

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- FETCH  in  1  fetch-phase strobe, one cycle per instruction.
- COMMIT  in  1  commit-phase strobe, one cycle per instruction, precedes the next FETCH.
- INT0  in  1  external request, highest priority, asynchronous level.
- INT1  in  1  external request, lower priority, asynchronous level.
- EI  in  1  decoder strobe (valid with COMMIT): set global enable.
- DI  in  1  decoder strobe (valid with COMMIT): clear global enable.
- RETI  in  1  decoder strobe (valid with COMMIT): return from interrupt.
- PC_NEXTX  out  3  next-address select to the program counter; encodings PC_NEXTX_* from constants.v.
- PC_LD_INT0X  out  1  save SUM into INTR0 (the program counter gates it with FETCH).
- PC_LD_INT1X  out  1  save SUM into INTR1.
- PC_FORCE_EN  out  1  high for an entry/return FETCH; the decoder ORs it into PC_ENX.
- INT_ACK0, INT_ACK1  out  1  one-cycle pulse on the entry FETCH.
- IE  out  1  global interrupt enable.
- IN_SVC0, IN_SVC1  out  1  in-service flags.

## Operation
- Synchronise each INTn through SYNC_STAGES flops, then detect the rising edge against a delay flop. An edge sets PENDn. PENDn clears only on the entry FETCH that services it. Further edges while PENDn=1 are merged.
- FSM states: RUN, ENT0, ENT1, RET0, RET1. All transitions out of RUN occur on a COMMIT cycle. All returns to RUN occur on the following FETCH cycle.
- Decision at COMMIT while in RUN, in this priority order:
  1. RETI with IN_SVC0=1 → RET0.
  2. RETI with IN_SVC1=1 (and IN_SVC0=0) → RET1.
  3. IE & PEND0 & !IN_SVC0 → ENT0.
  4. IE & PEND1 & !IN_SVC0 & !IN_SVC1 → ENT1.
  5. Otherwise stay in RUN.
- A RETI with no service bit set is ignored and the FSM stays in RUN.
- Nesting: INT0 may preempt an INT1 handler. INT1 never preempts INT0, and no level re-enters itself.
- When RETI and a pending request arrive on the same COMMIT, the return wins. The request is re-evaluated at the next COMMIT.
- EI/DI: evaluated at COMMIT. The IE update takes effect at the next COMMIT decision, not the same one. If EI and DI are asserted together, DI wins. Entry does not clear IE.
- Registered outputs per state:
  - RUN: PC_NEXTX=PC_NEXTX_NEXT, all strobes low.
  - ENT0: PC_NEXTX=PC_NEXTX_INTV0, PC_LD_INT0X=1, PC_FORCE_EN=1.
  - ENT1: PC_NEXTX=PC_NEXTX_INTV1, PC_LD_INT1X=1, PC_FORCE_EN=1.
  - RET0: PC_NEXTX=PC_NEXTX_INTR0, PC_FORCE_EN=1.
  - RET1: PC_NEXTX=PC_NEXTX_INTR1, PC_FORCE_EN=1.
- On the FETCH cycle in each state (state then returns to RUN):
  - ENTn: set IN_SVCn, clear PENDn, pulse INT_ACKn.
  - RETn: clear IN_SVCn.
- RESET_N low: state=RUN, PEND*=0, IN_SVC*=0, IE=0, synchronisers=0, PC_NEXTX=PC_NEXTX_NEXT, and all other outputs 0. A reset asserted mid-entry abandons the entry with no save.

## Timing
- INTn pin rising before edge k sets PENDn at edge k+SYNC_STAGES+1.
- PENDn set on or before the COMMIT edge → PC_NEXTX valid from the cycle after COMMIT through the FETCH cycle. Setup for the program counter's FETCH edge is always met.
- Entry latency: 1 COMMIT decision + 1 FETCH. The instruction committed at that COMMIT completes normally, and its successor address (SUM) is what gets saved.
- FETCH without a prior decision leaves the FSM in RUN, and outputs are unchanged.
- Back-to-back: RET1 followed immediately by a pending INT1 re-enters on the next instruction boundary.

## Test plan
- Reset, then IE=1 and INT1 pulsed → after the following COMMIT, PC_NEXTX=INTV1 and PC_LD_INT1X=1 for one FETCH. IN_SVC1=1 and INT_ACK1 pulses once.
- INT0 and INT1 rise on the same cycle with IE=1 → ENT0 first. INT1 stays pending until RETI from INT0 completes (PC_NEXTX=INTR0), and ENT1 follows at the next COMMIT.
- Inside an INT1 handler, INT0 rises → ENT0 preempts. RETI selects INTR0, then a second RETI selects INTR1. Both IN_SVC bits end at 0.
- IE=0 with INT0 pulsed → no entry and PEND0 held. EI at COMMIT n → entry decided at COMMIT n+1. EI and DI together → IE stays 0.
- RETI on the same COMMIT as a new PEND0 while IN_SVC1=1 → RET1 taken first, ENT0 at the next COMMIT.
- RESET_N asserted during the ENT0 state → all outputs at reset values immediately, no PC_LD_INT0X on the next FETCH.
